// File: rtl/hazard_ctrl.sv
// Scoreboard-based hazard and forwarding controller for the 5-stage pipe.
// Tracks in-flight GPR writers; emits forward selects, stalls, freezes, flushes.
module hazard_ctrl #(
  parameter  int REG_AW = 5,
  parameter  int DEPTH  = 3,
  parameter  int MC_LAT = 6,
  localparam int SEL_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_reg_we,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              ex_redirect,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              pipe_freeze,
  output logic              mc_done
);

  localparam int CW = $clog2(MC_LAT) + 1;

  typedef struct packed {
    logic              v;
    logic              we;
    logic [REG_AW-1:0] rw;
    logic              ld;
    logic              mc;
  } sb_t;

  sb_t             sb_q [DEPTH];
  sb_t             sb_d [DEPTH];
  logic [CW-1:0]   mc_cnt_q;
  logic [CW-1:0]   mc_cnt_d;
  logic [DEPTH-1:0] m_a;
  logic [DEPTH-1:0] m_b;
  logic            luse;
  logic            accept;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      m_a[k] = id_valid & id_rs1_used & (id_rs1 != '0)
             & sb_q[k].v & sb_q[k].we & (sb_q[k].rw == id_rs1);
      m_b[k] = id_valid & id_rs2_used & (id_rs2 != '0)
             & sb_q[k].v & sb_q[k].we & (sb_q[k].rw == id_rs2);
    end
  end

  // Scan oldest to youngest so the youngest match is the last written.
  // The WB entry is skipped: the regfile writes before it is read.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (m_a[k]) fwd_a_sel = SEL_W'(k + 1);
      if (m_b[k]) fwd_b_sel = SEL_W'(k + 1);
    end
  end

  always_comb begin
    luse        = (m_a[0] | m_b[0]) & sb_q[0].ld;
    pipe_freeze = (mc_cnt_q != '0);
    flush_id    = ex_redirect & ~pipe_freeze;
    stall_id    = pipe_freeze | (luse & ~ex_redirect);
    bubble_ex   = (luse | ex_redirect) & ~pipe_freeze;
    mc_done     = sb_q[0].v & sb_q[0].mc
                & ((mc_cnt_q == '0) | (MC_LAT == 1));
    accept      = id_valid & ~stall_id & ~bubble_ex;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) sb_d[k] = sb_q[k];
    mc_cnt_d = '0;
    if (pipe_freeze) begin
      mc_cnt_d = mc_cnt_q - CW'(1);
    end else begin
      for (int k = 1; k < DEPTH; k++) sb_d[k] = sb_q[k-1];
      sb_d[0].v  = accept;
      sb_d[0].we = id_reg_we;
      sb_d[0].rw = id_rw;
      sb_d[0].ld = id_is_load;
      sb_d[0].mc = id_is_mc;
      if (accept & id_is_mc) mc_cnt_d = CW'(MC_LAT - 1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) sb_q[k] <= '0;
      mc_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) sb_q[k] <= sb_d[k];
      mc_cnt_q <= mc_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios
// plus a randomized run against a stage-list reference model.
module tb_hazard_ctrl;

  localparam int DEPTH  = 3;
  localparam int MC_LAT = 6;

  logic       clock = 0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rw;
  logic       id_rs1_used, id_rs2_used, id_reg_we;
  logic       id_is_load, id_is_mc, ex_redirect;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_id, bubble_ex, flush_id, pipe_freeze, mc_done;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.REG_AW(5), .DEPTH(DEPTH), .MC_LAT(MC_LAT)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rw(id_rw), .id_reg_we(id_reg_we),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc),
    .ex_redirect(ex_redirect),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .pipe_freeze(pipe_freeze), .mc_done(mc_done)
  );

  always #5 clock = ~clock;

  wire [8:0] obs = {fwd_a_sel, fwd_b_sel, stall_id, bubble_ex,
                    flush_id, pipe_freeze, mc_done};

  function automatic logic [8:0] ev(int a, int b, bit st, bit bu,
                                    bit fl, bit fr, bit dn);
    return {a[1:0], b[1:0], st, bu, fl, fr, dn};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic nop();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0;
    id_rs2_used = 0; id_rw = 0; id_reg_we = 0; id_is_load = 0;
    id_is_mc = 0; ex_redirect = 0;
  endtask

  task automatic set_id(input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rw, input bit we,
                        input bit ld, input bit mc);
    id_valid = 1; id_rs1 = rs1[4:0]; id_rs1_used = u1;
    id_rs2 = rs2[4:0]; id_rs2_used = u2; id_rw = rw[4:0];
    id_reg_we = we; id_is_load = ld; id_is_mc = mc;
  endtask

  task automatic do_reset();
    nop(); reset = 1; cyc(); reset = 0;
  endtask

  task automatic drain();
    nop();
    repeat (DEPTH + 1) cyc();
  endtask

  task automatic test_reset();
    do_reset();
    set_id(3, 1, 4, 1, 5, 1, 0, 0);
    #1;
    checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL reset_state obs=%b exp=%b", obs, ev(0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_fwd();
    drain();
    set_id(1, 1, 2, 1, 3, 1, 0, 0); cyc();
    set_id(3, 1, 1, 1, 4, 1, 0, 0); #1;
    checks++;
    if (obs !== ev(1, 0, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL fwd_ex obs=%b exp=%b", obs, ev(1,0,0,0,0,0,0));
    end
    drain();
    set_id(1, 1, 2, 1, 3, 1, 0, 0); cyc();
    set_id(1, 1, 2, 1, 9, 1, 0, 0); cyc();
    set_id(1, 1, 3, 1, 5, 1, 0, 0); #1;
    checks++;
    if (obs !== ev(0, 2, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL fwd_mem obs=%b exp=%b", obs, ev(0,2,0,0,0,0,0));
    end
    drain();
    set_id(1, 1, 2, 1, 3, 1, 0, 0); cyc();
    set_id(1, 1, 2, 1, 3, 1, 0, 0); cyc();
    set_id(1, 1, 3, 1, 5, 1, 0, 0); #1;
    checks++;
    if (obs !== ev(0, 1, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL fwd_youngest obs=%b exp=%b", obs, ev(0,1,0,0,0,0,0));
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1, 1, 0, 0, 5, 1, 1, 0); cyc();
    set_id(5, 1, 5, 1, 6, 1, 0, 0); #1;
    checks++;
    if (obs !== ev(1, 1, 1, 1, 0, 0, 0)) begin
      failures++; $display("FAIL luse_stall obs=%b exp=%b", obs, ev(1,1,1,1,0,0,0));
    end
    cyc(); #1;
    checks++;
    if (obs !== ev(2, 2, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL luse_release obs=%b exp=%b", obs, ev(2,2,0,0,0,0,0));
    end
  endtask

  task automatic test_multicycle();
    drain();
    set_id(1, 1, 2, 1, 7, 1, 0, 1); cyc();
    set_id(7, 1, 1, 1, 8, 1, 0, 0);
    for (int i = 1; i < MC_LAT; i++) begin
      #1;
      checks++;
      if (obs !== ev(1, 0, 1, 0, 0, 1, 0)) begin
        failures++; $display("FAIL mc_freeze_%0d obs=%b exp=%b", i, obs, ev(1,0,1,0,0,1,0));
      end
      cyc();
    end
    #1;
    checks++;
    if (obs !== ev(1, 0, 0, 0, 0, 0, 1)) begin
      failures++; $display("FAIL mc_done obs=%b exp=%b", obs, ev(1,0,0,0,0,0,1));
    end
    cyc(); nop(); #1;
    checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL mc_after obs=%b exp=%b", obs, ev(0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_redirect();
    drain();
    set_id(1, 1, 0, 0, 5, 1, 1, 0); cyc();
    set_id(5, 1, 1, 1, 6, 1, 0, 0); ex_redirect = 1; #1;
    checks++;
    if (obs !== ev(1, 0, 0, 1, 1, 0, 0)) begin
      failures++; $display("FAIL redirect_luse obs=%b exp=%b", obs, ev(1,0,0,1,1,0,0));
    end
    drain();
    set_id(1, 1, 2, 1, 7, 1, 0, 1); cyc();
    set_id(7, 1, 0, 0, 8, 1, 0, 0); ex_redirect = 1; #1;
    checks++;
    if (obs !== ev(1, 0, 1, 0, 0, 1, 0)) begin
      failures++; $display("FAIL redirect_frozen obs=%b exp=%b", obs, ev(1,0,1,0,0,1,0));
    end
    ex_redirect = 0; reset = 1; cyc(); reset = 0; #1;
    checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL reset_in_freeze obs=%b exp=%b", obs, ev(0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_r0_and_invalid();
    drain();
    set_id(1, 1, 2, 1, 0, 1, 0, 0); cyc();
    set_id(0, 1, 0, 1, 4, 1, 0, 0); #1;
    checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL r0_nofwd obs=%b exp=%b", obs, ev(0,0,0,0,0,0,0));
    end
    drain();
    set_id(1, 1, 0, 0, 5, 1, 1, 0); cyc();
    set_id(5, 1, 5, 1, 6, 1, 0, 0); id_valid = 0; #1;
    checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL invalid_id obs=%b exp=%b", obs, ev(0,0,0,0,0,0,0));
    end
  endtask

  typedef struct {
    bit v; bit we; int rw; bit ld; bit mc;
  } ent_t;

  function automatic bit hit(ent_t e, bit vld, int rs, bit used);
    return vld && used && rs != 0 && e.v && e.we && e.rw == rs;
  endfunction

  // Model: list of instructions by stage plus the age of the op in EX.
  task automatic test_random();
    ent_t mp [DEPTH];
    int mage, ea, eb;
    bit efr, edn, eluse, est, ebu, efl;
    logic [8:0] e;
    do_reset();
    for (int k = 0; k < DEPTH; k++) mp[k] = '{0, 0, 0, 0, 0};
    mage = 0;
    for (int n = 0; n < 800; n++) begin
      reset       = ($urandom_range(63) == 0);
      id_valid    = ($urandom_range(3) != 0);
      id_rs1      = 5'($urandom_range(7));
      id_rs2      = 5'($urandom_range(7));
      id_rw       = 5'($urandom_range(7));
      id_rs1_used = ($urandom_range(4) != 0);
      id_rs2_used = ($urandom_range(2) != 0);
      id_reg_we   = ($urandom_range(5) != 0);
      id_is_load  = ($urandom_range(3) == 0);
      id_is_mc    = !id_is_load && ($urandom_range(11) == 0);
      ex_redirect = ($urandom_range(9) == 0);
      #1;
      ea = 0; eb = 0;
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (ea == 0 && hit(mp[k], id_valid, int'(id_rs1), id_rs1_used)) ea = k + 1;
        if (eb == 0 && hit(mp[k], id_valid, int'(id_rs2), id_rs2_used)) eb = k + 1;
      end
      eluse = mp[0].ld &&
              (hit(mp[0], id_valid, int'(id_rs1), id_rs1_used) ||
               hit(mp[0], id_valid, int'(id_rs2), id_rs2_used));
      efr = mp[0].v && mp[0].mc && mage < MC_LAT;
      edn = mp[0].v && mp[0].mc && mage >= MC_LAT;
      efl = ex_redirect && !efr;
      est = efr || (eluse && !ex_redirect);
      ebu = (eluse || ex_redirect) && !efr;
      e = ev(ea, eb, est, ebu, efl, efr, edn);
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL rand_%0d obs=%b exp=%b", n, obs, e);
      end
      cyc();
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) mp[k] = '{0, 0, 0, 0, 0};
        mage = 0;
      end else if (efr) begin
        mage++;
      end else begin
        for (int k = DEPTH - 1; k > 0; k--) mp[k] = mp[k-1];
        mp[0].v  = id_valid && !est && !ebu;
        mp[0].we = id_reg_we;
        mp[0].rw = int'(id_rw);
        mp[0].ld = id_is_load;
        mp[0].mc = id_is_mc;
        mage = 1;
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    nop();
    test_reset();
    test_fwd();
    test_load_use();
    test_multicycle();
    test_redirect();
    test_r0_and_invalid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
